// File: rtl/ccb_cmd_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : ccb_cmd_receiver_if
// Description : CCB backplane bus plus event-FIFO access signals for the
//               CCB command receiver. The master modport drives the bus
//               and reads the FIFO. The slave modport is the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface ccb_cmd_receiver_if #(
   parameter int TS_WIDTH = 16
);
   // Control and backplane inputs to the receiver
   logic                    en;
   logic                    ccb_cmd_s;
   logic [5:0]              ccb_cmd;
   logic                    ccb_data_s;
   logic [7:0]              ccb_data;
   logic [2:0]              ccb_cal;
   // Decoded outputs
   logic                    bc0;
   logic                    l1_reset;
   logic                    soft_reset;
   logic                    unk_cmd;
   logic                    data_valid;
   logic [7:0]              data_out;
   logic [2:0]              cal_pulse;
   // Event FIFO access
   logic [16+TS_WIDTH-1:0]  fifo_dout;
   logic                    fifo_empty;
   logic                    fifo_rd;
   logic                    overflow;
   logic [7:0]              drop_cnt;
   logic                    clr_ovf;

   modport master (
      output en, ccb_cmd_s, ccb_cmd, ccb_data_s, ccb_data, ccb_cal, fifo_rd, clr_ovf,
      input  bc0, l1_reset, soft_reset, unk_cmd, data_valid, data_out, cal_pulse,
             fifo_dout, fifo_empty, overflow, drop_cnt
   );

   modport slave (
      input  en, ccb_cmd_s, ccb_cmd, ccb_data_s, ccb_data, ccb_cal, fifo_rd, clr_ovf,
      output bc0, l1_reset, soft_reset, unk_cmd, data_valid, data_out, cal_pulse,
             fifo_dout, fifo_empty, overflow, drop_cnt
   );
endinterface
`default_nettype wire

// File: rtl/ccb_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ccb_cmd_receiver
// Description : Receive end of the CCB backplane command bus. It registers
//               the active-low strobes and decodes fixed commands into
//               1-clk pulses. It latches the data byte, and it logs every
//               strobed cycle with a timestamp into a first-word-fall-through
//               event FIFO.
//               Optional feature macro: CCB_CAL_DECODE_EN enables
//               calibration strobe decoding on cal_pulse. Without it,
//               cal_pulse is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ccb_cmd_receiver #(
   parameter int         FIFO_DEPTH  = 8,
   parameter int         TS_WIDTH    = 16,
   parameter logic [5:0] CMD_BC0     = 6'h01,
   parameter logic [5:0] CMD_L1RST   = 6'h03,
   parameter logic [5:0] CMD_SOFTRST = 6'h05
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   ccb_cmd_receiver_if.slave  bus
);
   localparam int c_entry_w = 16 + TS_WIDTH;
   localparam int c_aw      = $clog2(FIFO_DEPTH);

   localparam logic [c_aw-1:0]     c_ptr_one  = c_aw'(1);
   localparam logic [c_aw:0]       c_cnt_one  = (c_aw + 1)'(1);
   localparam logic [c_aw:0]       c_cnt_full = (c_aw + 1)'(FIFO_DEPTH);
   localparam logic [TS_WIDTH-1:0] c_ts_one   = TS_WIDTH'(1);

   // Stage-1 bus registers
   logic                 r_cmd_s;
   logic [5:0]           r_cmd;
   logic                 r_data_s;
   logic [7:0]           r_data;
   logic [TS_WIDTH-1:0]  r_s1_ts;

   // Timestamp counter
   logic [TS_WIDTH-1:0]  r_ts;

   // Stage-2 decode outputs
   logic                 r_bc0;
   logic                 r_l1_reset;
   logic                 r_soft_reset;
   logic                 r_unk_cmd;
   logic                 r_data_valid;
   logic [7:0]           r_data_out;

   // Event FIFO state
   logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
   logic [c_aw-1:0]      r_wr_ptr;
   logic [c_aw-1:0]      r_rd_ptr;
   logic [c_aw:0]        r_count;
   logic                 r_overflow;
   logic [7:0]           r_drop_cnt;

   logic                 w_cmd_ev;
   logic                 w_data_ev;
   logic                 w_is_bc0;
   logic                 w_is_l1;
   logic                 w_is_soft;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_do_push;
   logic                 w_drop;
   logic [c_entry_w-1:0] w_entry;
   logic [c_aw:0]        w_cnt_next;

   // Each cycle with a registered strobe low is one event; there is no edge detection
   assign w_cmd_ev  = bus.en && !r_cmd_s;
   assign w_data_ev = bus.en && !r_data_s;
   assign w_is_bc0  = (r_cmd == CMD_BC0);
   assign w_is_l1   = (r_cmd == CMD_L1RST);
   assign w_is_soft = (r_cmd == CMD_SOFTRST);

   // A cycle with both strobes low produces one entry. The field without a flag is zeroed.
   assign w_push  = w_cmd_ev || w_data_ev;
   assign w_entry = {w_cmd_ev, w_data_ev,
                     (w_cmd_ev  ? r_cmd  : 6'h00),
                     (w_data_ev ? r_data : 8'h00),
                     r_s1_ts};

   // A pop frees a slot before the push in the same cycle, so full+push+pop does not drop
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_cnt_full);
   assign w_pop     = bus.fifo_rd && !w_empty;
   assign w_do_push = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && w_full && !w_pop;

   // Occupancy after this cycle's push and pop
   always_comb begin
      w_cnt_next = r_count;
      if (w_do_push && !w_pop) begin
         w_cnt_next = r_count + c_cnt_one;
      end else if (!w_do_push && w_pop) begin
         w_cnt_next = r_count - c_cnt_one;
      end
   end

   // Stage 1: sample the whole bus and the current timestamp every clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_s  <= 1'b1;
         r_cmd    <= 6'h00;
         r_data_s <= 1'b1;
         r_data   <= 8'h00;
         r_s1_ts  <= '0;
      end else begin
         r_cmd_s  <= bus.ccb_cmd_s;
         r_cmd    <= bus.ccb_cmd;
         r_data_s <= bus.ccb_data_s;
         r_data   <= bus.ccb_data;
         r_s1_ts  <= r_ts;
      end
   end

   // Free-running timestamp, frozen while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts <= '0;
      end else if (bus.en) begin
         r_ts <= r_ts + c_ts_one;
      end
   end

   // Stage 2: decode registered strobes into single-cycle pulses and hold the data byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bc0        <= 1'b0;
         r_l1_reset   <= 1'b0;
         r_soft_reset <= 1'b0;
         r_unk_cmd    <= 1'b0;
         r_data_valid <= 1'b0;
         r_data_out   <= 8'h00;
      end else begin
         r_bc0        <= w_cmd_ev && w_is_bc0;
         r_l1_reset   <= w_cmd_ev && w_is_l1;
         r_soft_reset <= w_cmd_ev && w_is_soft;
         r_unk_cmd    <= w_cmd_ev && !(w_is_bc0 || w_is_l1 || w_is_soft);
         r_data_valid <= w_data_ev;
         if (w_data_ev) begin
            r_data_out <= r_data;
         end
      end
   end

   // FIFO pointers, occupancy and drop accounting. A drop in the same cycle as clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= 8'h00;
      end else begin
         r_count <= w_cnt_next;
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (bus.clr_ovf) begin
               r_drop_cnt <= 8'h01;
            end else if (r_drop_cnt != 8'hFF) begin
               r_drop_cnt <= r_drop_cnt + 8'h01;
            end
         end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'h00;
         end
      end
   end

   // FIFO storage. Contents need no reset because the output is masked while empty.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

`ifdef CCB_CAL_DECODE_EN
   logic [2:0] r_cal;
   logic [2:0] r_cal_pulse;

   // Stage 1 for the calibration strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cal <= 3'b111;
      end else begin
         r_cal <= bus.ccb_cal;
      end
   end

   // Stage 2: each low calibration strobe gives a pulse. These pulses never touch the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cal_pulse <= 3'b000;
      end else begin
         r_cal_pulse <= bus.en ? ~r_cal : 3'b000;
      end
   end

   assign bus.cal_pulse = r_cal_pulse;
`else
   assign bus.cal_pulse = 3'b000;
`endif

   assign bus.bc0        = r_bc0;
   assign bus.l1_reset   = r_l1_reset;
   assign bus.soft_reset = r_soft_reset;
   assign bus.unk_cmd    = r_unk_cmd;
   assign bus.data_valid = r_data_valid;
   assign bus.data_out   = r_data_out;
   assign bus.fifo_empty = w_empty;
   assign bus.fifo_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign bus.overflow   = r_overflow;
   assign bus.drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ccb_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccb_cmd_receiver
// Description : Self-checking bench for ccb_cmd_receiver. A queue-based
//               reference model tracks pulses, the data byte, the event
//               FIFO and drop accounting. Directed scenarios are followed
//               by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccb_cmd_receiver;
   localparam int DEPTH = 8;
   localparam int TSW   = 16;
   localparam int EW    = 16 + TSW;
`ifdef CCB_CAL_DECODE_EN
   localparam bit CAL_EN = 1'b1;
`else
   localparam bit CAL_EN = 1'b0;
`endif
   // Observed vector: pulses(8) data_out(8) empty(1) dout(32) overflow(1) drop_cnt(8)
   localparam logic [57:0] C_RESET_OBS = 58'h1 << 41;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ccb_cmd_receiver_if #(.TS_WIDTH(TSW)) bus ();
   ccb_cmd_receiver #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [EW-1:0]  q[$];
   logic [TSW-1:0] m_ts;
   logic [7:0]     m_pulse;
   logic [7:0]     m_data_out;
   logic [7:0]     m_drop;
   logic           m_ovf;
   logic           s1_cmd_s, s1_data_s;
   logic [5:0]     s1_cmd;
   logic [7:0]     s1_data;
   logic [2:0]     s1_cal;
   logic [TSW-1:0] s1_ts;

   wire [57:0] obs = {bus.bc0, bus.l1_reset, bus.soft_reset, bus.unk_cmd, bus.data_valid,
                      bus.cal_pulse, bus.data_out, bus.fifo_empty, bus.fifo_dout,
                      bus.overflow, bus.drop_cnt};

   function automatic logic [57:0] model_obs();
      logic [EW-1:0] head;
      logic          emp;
      emp  = (q.size() == 0);
      head = emp ? '0 : q[0];
      return {m_pulse, m_data_out, emp, head, m_ovf, m_drop};
   endfunction

   task automatic model_reset();
      q.delete();
      m_ts = '0; m_pulse = '0; m_data_out = '0; m_drop = '0; m_ovf = 1'b0;
      s1_cmd_s = 1'b1; s1_data_s = 1'b1; s1_cmd = '0; s1_data = '0; s1_cal = 3'b111; s1_ts = '0;
   endtask

   task automatic idle_inputs();
      bus.ccb_cmd_s = 1'b1; bus.ccb_cmd = 6'h00; bus.ccb_data_s = 1'b1; bus.ccb_data = 8'h00;
      bus.ccb_cal = 3'b111; bus.fifo_rd = 1'b0; bus.clr_ovf = 1'b0;
   endtask

   // Advance one clock. The model applies the rules to the values that were sampled on the previous edge.
   task automatic tick();
      logic cev, dev;
      @(posedge clk);
      cev = bus.en && !s1_cmd_s;
      dev = bus.en && !s1_data_s;
      m_pulse = '0;
      if (cev) begin
         case (s1_cmd)
            6'h01:   m_pulse[7] = 1'b1;
            6'h03:   m_pulse[6] = 1'b1;
            6'h05:   m_pulse[5] = 1'b1;
            default: m_pulse[4] = 1'b1;
         endcase
      end
      if (dev) begin
         m_pulse[3] = 1'b1;
         m_data_out = s1_data;
      end
      if (CAL_EN && bus.en) m_pulse[2:0] = ~s1_cal;
      if (bus.fifo_rd && q.size() > 0) void'(q.pop_front());
      if (bus.clr_ovf) begin
         m_ovf = 1'b0;
         m_drop = 8'h00;
      end
      if (cev || dev) begin
         if (q.size() < DEPTH) begin
            q.push_back({cev, dev, (cev ? s1_cmd : 6'h00), (dev ? s1_data : 8'h00), s1_ts});
         end else begin
            m_ovf = 1'b1;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'h01;
         end
      end
      s1_cmd_s = bus.ccb_cmd_s; s1_cmd = bus.ccb_cmd; s1_data_s = bus.ccb_data_s;
      s1_data = bus.ccb_data; s1_cal = bus.ccb_cal; s1_ts = m_ts;
      if (bus.en) m_ts = m_ts + 1'b1;
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.en = 1'b1;
      do_reset();
      checks++;
      if (obs !== C_RESET_OBS) begin
         errors++; $display("FAIL reset_state: got %h expected %h", obs, C_RESET_OBS);
      end
      repeat (100) begin
         tick();
         checks++;
         if (obs !== model_obs()) begin
            errors++; $display("FAIL idle_bus: got %h expected %h", obs, model_obs());
         end
      end
      bus.ccb_cmd_s = 1'b0; bus.ccb_cmd = 6'h03;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.l1_reset !== 1'b1 || bus.fifo_dout !== {2'b10, 6'h03, 8'h00, 16'd100}) begin
         errors++; $display("FAIL ts_after_100: got l1=%b dout=%h expected l1=1 dout=%h",
                            bus.l1_reset, bus.fifo_dout, {2'b10, 6'h03, 8'h00, 16'd100});
      end
   endtask

   task automatic test_bc0();
      do_reset();
      repeat (5) tick();
      bus.ccb_cmd_s = 1'b0; bus.ccb_cmd = 6'h01;
      tick();
      idle_inputs();
      checks++;
      if (bus.bc0 !== 1'b0) begin
         errors++; $display("FAIL bc0_latency1: got %b expected 0", bus.bc0);
      end
      tick();
      checks++;
      if (bus.bc0 !== 1'b1 || bus.fifo_dout !== {1'b1, 1'b0, 6'h01, 8'h00, 16'd5} || obs !== model_obs()) begin
         errors++; $display("FAIL bc0_entry: got bc0=%b dout=%h expected bc0=1 dout=%h",
                            bus.bc0, bus.fifo_dout, {1'b1, 1'b0, 6'h01, 8'h00, 16'd5});
      end
      tick();
      checks++;
      if (bus.bc0 !== 1'b0) begin
         errors++; $display("FAIL bc0_width: got %b expected 0", bus.bc0);
      end
   endtask

   task automatic test_unk_burst();
      logic [TSW-1:0] t0;
      int n_unk = 0;
      do_reset();
      repeat (3) tick();
      t0 = m_ts;
      bus.ccb_cmd_s = 1'b0; bus.ccb_cmd = 6'h3F;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) idle_inputs();
         tick();
         if (bus.unk_cmd === 1'b1) n_unk++;
      end
      checks++;
      if (n_unk != 3) begin
         errors++; $display("FAIL unk_count: got %0d expected 3", n_unk);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.fifo_dout !== {2'b10, 6'h3F, 8'h00, t0 + TSW'(i)}) begin
            errors++; $display("FAIL unk_entry%0d: got %h expected %h", i, bus.fifo_dout,
                               {2'b10, 6'h3F, 8'h00, t0 + TSW'(i)});
         end
         bus.fifo_rd = 1'b1;
         tick();
         bus.fifo_rd = 1'b0;
      end
      checks++;
      if (bus.fifo_empty !== 1'b1) begin
         errors++; $display("FAIL unk_drain: got empty=%b expected 1", bus.fifo_empty);
      end
   endtask

   task automatic test_cmd_data_same();
      do_reset();
      tick();
      bus.ccb_cmd_s = 1'b0; bus.ccb_cmd = 6'h05; bus.ccb_data_s = 1'b0; bus.ccb_data = 8'hA5;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.soft_reset !== 1'b1 || bus.data_valid !== 1'b1 || bus.data_out !== 8'hA5 ||
          bus.fifo_dout[31:16] !== {2'b11, 6'h05, 8'hA5}) begin
         errors++; $display("FAIL cmd_data_same: got soft=%b dv=%b data=%h hdr=%h expected 1 1 a5 %h",
                            bus.soft_reset, bus.data_valid, bus.data_out, bus.fifo_dout[31:16], {2'b11, 6'h05, 8'hA5});
      end
      bus.fifo_rd = 1'b1;
      tick();
      bus.fifo_rd = 1'b0;
      checks++;
      if (bus.fifo_empty !== 1'b1 || bus.data_out !== 8'hA5 || bus.data_valid !== 1'b0) begin
         errors++; $display("FAIL single_entry: got empty=%b data=%h dv=%b expected 1 a5 0",
                            bus.fifo_empty, bus.data_out, bus.data_valid);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      bus.ccb_cmd_s = 1'b0; bus.ccb_cmd = 6'h01; bus.ccb_data_s = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.ccb_data = 8'(i);
         tick();
      end
      idle_inputs();
      repeat (2) tick();
      checks++;
      if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd2 || obs !== model_obs()) begin
         errors++; $display("FAIL overflow_10: got ovf=%b drops=%0d expected ovf=1 drops=2", bus.overflow, bus.drop_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.fifo_empty !== 1'b0 || bus.fifo_dout[23:16] !== 8'(i)) begin
            errors++; $display("FAIL order%0d: got empty=%b data=%h expected 0 %h", i, bus.fifo_empty, bus.fifo_dout[23:16], 8'(i));
         end
         bus.fifo_rd = 1'b1;
         tick();
      end
      tick();
      bus.fifo_rd = 1'b0;
      bus.clr_ovf = 1'b1;
      tick();
      bus.clr_ovf = 1'b0;
      checks++;
      if (bus.fifo_empty !== 1'b1 || bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
         errors++; $display("FAIL clr_ovf: got empty=%b ovf=%b drops=%0d expected 1 0 0", bus.fifo_empty, bus.overflow, bus.drop_cnt);
      end
      // Fill to full, then push and pop in the same cycle
      bus.ccb_cmd_s = 1'b0;
      repeat (8) tick();
      idle_inputs();
      tick();
      bus.ccb_cmd_s = 1'b0;
      tick();
      idle_inputs();
      bus.fifo_rd = 1'b1;
      tick();
      bus.fifo_rd = 1'b0;
      checks++;
      if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0 || obs !== model_obs()) begin
         errors++; $display("FAIL full_push_pop: got ovf=%b drops=%0d expected 0 0", bus.overflow, bus.drop_cnt);
      end
      // A drop and clr_ovf in the same cycle
      bus.ccb_cmd_s = 1'b0;
      tick();
      idle_inputs();
      bus.clr_ovf = 1'b1;
      tick();
      bus.clr_ovf = 1'b0;
      checks++;
      if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin
         errors++; $display("FAIL drop_vs_clr: got ovf=%b drops=%0d expected 1 1", bus.overflow, bus.drop_cnt);
      end
      bus.ccb_cmd_s = 1'b0;
      repeat (300) tick();
      idle_inputs();
      repeat (2) tick();
      checks++;
      if (bus.drop_cnt !== 8'd255 || obs !== model_obs()) begin
         errors++; $display("FAIL drop_saturate: got %0d expected 255", bus.drop_cnt);
      end
   endtask

   task automatic test_en_off();
      do_reset();
      repeat (3) tick();
      bus.en = 1'b0;
      bus.ccb_cmd_s = 1'b0; bus.ccb_cmd = 6'h01; bus.ccb_data_s = 1'b0; bus.ccb_data = 8'h3C;
      bus.ccb_cal = 3'b000;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) idle_inputs();
         tick();
         checks++;
         if (obs[57:50] !== 8'h00 || bus.fifo_empty !== 1'b1 || obs !== model_obs()) begin
            errors++; $display("FAIL en_off%0d: got pulses=%h empty=%b expected 00 1", i, obs[57:50], bus.fifo_empty);
         end
      end
      bus.en = 1'b1; bus.ccb_cmd_s = 1'b0; bus.ccb_cmd = 6'h01;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.fifo_dout !== {2'b10, 6'h01, 8'h00, 16'd3}) begin
         errors++; $display("FAIL ts_hold: got %h expected %h", bus.fifo_dout, {2'b10, 6'h01, 8'h00, 16'd3});
      end
      bus.en = 1'b0; bus.fifo_rd = 1'b1;
      tick();
      bus.fifo_rd = 1'b0; bus.en = 1'b1;
      checks++;
      if (bus.fifo_empty !== 1'b1) begin
         errors++; $display("FAIL rd_while_off: got empty=%b expected 1", bus.fifo_empty);
      end
   endtask

   task automatic test_cal();
      logic [2:0] exp_cal;
      exp_cal = CAL_EN ? 3'b001 : 3'b000;
      do_reset();
      tick();
      bus.ccb_cal = 3'b110;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.cal_pulse !== exp_cal || bus.fifo_empty !== 1'b1) begin
         errors++; $display("FAIL cal_pulse: got cal=%b empty=%b expected %b 1", bus.cal_pulse, bus.fifo_empty, exp_cal);
      end
      tick();
      checks++;
      if (bus.cal_pulse !== 3'b000) begin
         errors++; $display("FAIL cal_width: got %b expected 000", bus.cal_pulse);
      end
   endtask

   task automatic test_random();
      do_reset();
      repeat (600) begin
         bus.en         = ($urandom_range(0, 9) != 0);
         bus.ccb_cmd_s  = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0:       bus.ccb_cmd = 6'h01;
            1:       bus.ccb_cmd = 6'h03;
            2:       bus.ccb_cmd = 6'h05;
            default: bus.ccb_cmd = 6'($urandom);
         endcase
         bus.ccb_data_s = ($urandom_range(0, 2) != 0);
         bus.ccb_data   = 8'($urandom);
         bus.ccb_cal    = 3'($urandom);
         bus.fifo_rd    = ($urandom_range(0, 2) == 0);
         bus.clr_ovf    = ($urandom_range(0, 19) == 0);
         tick();
         checks++;
         if (obs !== model_obs()) begin
            errors++; $display("FAIL random: got %h expected %h", obs, model_obs());
         end
      end
      idle_inputs();
      bus.en = 1'b1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.ccb_cmd_s = 1'b0; bus.ccb_cmd = 6'h05; bus.ccb_data_s = 1'b0; bus.ccb_data = 8'h77;
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (obs !== C_RESET_OBS) begin
         errors++; $display("FAIL reset_mid: got %h expected %h", obs, C_RESET_OBS);
      end
      idle_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         checks++;
         if (obs !== model_obs()) begin
            errors++; $display("FAIL after_reset: got %h expected %h", obs, model_obs());
         end
      end
   endtask

   initial begin
      bus.en = 1'b1;
      idle_inputs();
      model_reset();
      test_reset();
      test_bc0();
      test_unk_burst();
      test_cmd_data_same();
      test_overflow();
      test_en_off();
      test_cal();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
